// File: rtl/addr_gen_pkg.sv
// rtl/addr_gen_pkg.sv - shared types and constants for the matrix-multiply address generator
package addr_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

  localparam int K_RESET_DEF = 332;

endpackage

// File: rtl/walk_counter.sv
// rtl/walk_counter.sv - 2-D row/column trip counter with wrap and terminal-count flags
module walk_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  input  logic [CW-1:0] rows,
  input  logic [CW-1:0] cols,
  output logic          col_end,
  output logic          row_end
);

  logic [CW-1:0] r_rows;
  logic [CW-1:0] r_cols;
  logic [CW-1:0] r_r;
  logic [CW-1:0] r_c;

  assign col_end = (r_c == r_cols - CW'(1));
  assign row_end = (r_r == r_rows - CW'(1));

  // The terminal position holds; the owner leaves WALK on that step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rows <= '0;
      r_cols <= '0;
      r_r    <= '0;
      r_c    <= '0;
    end else if (clr) begin
      r_rows <= rows;
      r_cols <= cols;
      r_r    <= '0;
      r_c    <= '0;
    end else if (adv) begin
      if (!col_end) begin
        r_c <= r_c + CW'(1);
      end else if (!row_end) begin
        r_c <= '0;
        r_r <= r_r + CW'(1);
      end
    end
  end

endmodule

// File: rtl/addr_gen_ac.sv
// rtl/addr_gen_ac.sv - address generator with manual load/inc/inc-by-k ops and an autonomous 2-D walk
module addr_gen_ac
  import addr_gen_pkg::*;
#(
  parameter int AW      = 16,
  parameter int CW      = 16,
  parameter int K_RESET = K_RESET_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_enable,
  input  logic [AW-1:0] data_in,
  input  logic          inc,
  input  logic          inck,
  input  logic          k_load,
  input  logic [AW-1:0] k_in,
  input  logic          start,
  input  logic          mode,
  input  logic [CW-1:0] rows,
  input  logic [CW-1:0] cols,
  input  logic          step,
  output logic [AW-1:0] data_out,
  output logic [AW-1:0] k_out,
  output logic          busy,
  output logic          last,
  output logic          done
);

  state_t        r_state;
  logic [AW-1:0] r_data_out;
  logic [AW-1:0] r_k;
  logic [AW-1:0] r_line_base;
  logic          r_mode;
  logic          r_done;

  logic          w_dims_ok;
  logic          w_clr;
  logic          w_adv;
  logic          w_col_end;
  logic          w_row_end;
  logic [AW-1:0] w_inner_step;
  logic [AW-1:0] w_next_line;

  assign w_dims_ok    = (rows != '0) && (cols != '0);
  assign w_clr        = (r_state == IDLE) && start && w_dims_ok;
  assign w_adv        = (r_state == WALK) && step;
  assign w_inner_step = (r_mode == MODE_COL) ? r_k : AW'(1);
  assign w_next_line  = r_line_base + ((r_mode == MODE_COL) ? AW'(1) : r_k);

  walk_counter #(
    .CW(CW)
  ) u_walk_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_clr),
    .adv     (w_adv),
    .rows    (rows),
    .cols    (cols),
    .col_end (w_col_end),
    .row_end (w_row_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_data_out  <= '0;
      r_k         <= AW'(K_RESET);
      r_line_base <= '0;
      r_mode      <= MODE_ROW;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (k_load) begin
        r_k <= k_in;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            // Degenerate walk: report completion without touching the address.
            if (!w_dims_ok) begin
              r_done <= 1'b1;
            end else begin
              r_data_out  <= data_in;
              r_line_base <= data_in;
              r_mode      <= mode;
              r_state     <= WALK;
            end
          end else if (inck) begin
            r_data_out <= r_data_out + r_k;
          end else if (inc) begin
            r_data_out <= r_data_out + AW'(1);
          end else if (load_enable) begin
            r_data_out <= data_in;
          end
        end
        WALK: begin
          if (step) begin
            if (!w_col_end) begin
              r_data_out <= r_data_out + w_inner_step;
            end else if (!w_row_end) begin
              r_line_base <= w_next_line;
              r_data_out  <= w_next_line;
            end else begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out = r_data_out;
  assign k_out    = r_k;
  assign busy     = (r_state == WALK);
  assign last     = busy && w_row_end && w_col_end;
  assign done     = r_done;

endmodule

// File: tb/tb_addr_gen_ac.sv
// tb/tb_addr_gen_ac.sv - self-checking bench for addr_gen_ac with a list-based walk model
module tb_addr_gen_ac;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_enable;
  logic [15:0] data_in;
  logic        inc;
  logic        inck;
  logic        k_load;
  logic [15:0] k_in;
  logic        start;
  logic        mode;
  logic [15:0] rows;
  logic [15:0] cols;
  logic        step;
  logic [15:0] data_out;
  logic [15:0] k_out;
  logic        busy;
  logic        last;
  logic        done;

  int total = 0;
  int bad   = 0;

  addr_gen_ac dut (
    .clk         (clk),
    .reset       (reset),
    .load_enable (load_enable),
    .data_in     (data_in),
    .inc         (inc),
    .inck        (inck),
    .k_load      (k_load),
    .k_in        (k_in),
    .start       (start),
    .mode        (mode),
    .rows        (rows),
    .cols        (cols),
    .step        (step),
    .data_out    (data_out),
    .k_out       (k_out),
    .busy        (busy),
    .last        (last),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_enable = 0; inc = 0; inck = 0; k_load = 0; start = 0; step = 0;
  endtask

  task automatic set_k(input logic [15:0] kk);
    k_load = 1; k_in = kk;
    tick();
    k_load = 0;
  endtask

  // Expected element sequence, computed directly from outer/inner index arithmetic.
  task automatic run_walk(input string name, input logic [15:0] base, input logic [15:0] kk,
                          input logic m, input int nr, input int nc,
                          input int stall_pct, input int stall_at);
    logic [15:0] q[$];
    logic [15:0] a;
    int idx, cycles, held;
    q = {};
    for (int o = 0; o < nr; o++)
      for (int i = 0; i < nc; i++) begin
        a = base + (m ? 16'(i * int'(kk) + o) : 16'(o * int'(kk) + i));
        q.push_back(a);
      end
    start = 1; data_in = base; mode = m; rows = 16'(nr); cols = 16'(nc);
    tick();
    start = 0;
    idx = 0; cycles = 0; held = 0;
    while (idx < q.size() && cycles < 2000) begin
      total++;
      if (data_out !== q[idx] || busy !== 1'b1 || done !== 1'b0 || last !== (idx == q.size() - 1)) begin
        bad++;
        $display("FAIL %s elem%0d: got addr=%h busy=%b done=%b last=%b, want addr=%h busy=1 done=0 last=%b",
                 name, idx, data_out, busy, done, last, q[idx], (idx == q.size() - 1));
      end
      if (idx == stall_at && held < 2) begin
        step = 0;
        held++;
      end else begin
        step = ($urandom_range(99) >= stall_pct);
      end
      tick();
      if (step) idx++;
      cycles++;
    end
    step = 0;
    total++;
    if (cycles >= 2000) begin
      bad++;
      $display("FAIL %s timeout: reached elem %0d of %0d", name, idx, q.size());
    end else if (done !== 1'b1 || busy !== 1'b0 || data_out !== q[q.size() - 1]) begin
      bad++;
      $display("FAIL %s finish: got done=%b busy=%b addr=%h, want done=1 busy=0 addr=%h",
               name, done, busy, data_out, q[q.size() - 1]);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    data_in = 0; k_in = 0; mode = 0; rows = 0; cols = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    total++;
    if (data_out !== 16'd0 || k_out !== 16'd332 || busy !== 0 || done !== 0 || last !== 0) begin
      bad++;
      $display("FAIL reset: got addr=%h k=%0d busy=%b done=%b last=%b, want 0 332 0 0 0",
               data_out, k_out, busy, done, last);
    end
  endtask

  task automatic test_manual();
    inck = 1; tick(); inck = 0;
    total++;
    if (data_out !== 16'd332) begin bad++; $display("FAIL inck: got %0d want 332", data_out); end
    inc = 1; tick(); inc = 0;
    total++;
    if (data_out !== 16'd333) begin bad++; $display("FAIL inc: got %0d want 333", data_out); end
    load_enable = 1; data_in = 5; tick(); load_enable = 0;
    total++;
    if (data_out !== 16'd5) begin bad++; $display("FAIL load: got %0d want 5", data_out); end
  endtask

  task automatic test_priority();
    load_enable = 1; data_in = 10; tick();
    inc = 1; inck = 1; data_in = 99; tick();
    idle_inputs();
    total++;
    if (data_out !== 16'd342) begin bad++; $display("FAIL priority: got %0d want 342", data_out); end
    reset = 1; inck = 1; tick();
    reset = 0; inck = 0;
    total++;
    if (data_out !== 16'd0) begin bad++; $display("FAIL reset_vs_inck: got %0d want 0", data_out); end
  endtask

  task automatic test_row_walk();
    set_k(16'd4);
    total++;
    if (k_out !== 16'd4) begin bad++; $display("FAIL k_load: got %0d want 4", k_out); end
    run_walk("row_walk", 16'd100, 16'd4, 1'b0, 2, 3, 0, -1);
    tick();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got done=%b want 0", done); end
  endtask

  task automatic test_col_walk_stall();
    run_walk("col_walk_stall", 16'd100, 16'd4, 1'b1, 2, 3, 0, 2);
    tick();
  endtask

  task automatic test_zero_dims();
    load_enable = 1; data_in = 16'd77; tick(); load_enable = 0;
    start = 1; rows = 0; cols = 3; data_in = 16'd500; tick(); start = 0;
    total++;
    if (done !== 1 || busy !== 0 || data_out !== 16'd77) begin
      bad++;
      $display("FAIL zero_rows: got done=%b busy=%b addr=%0d, want 1 0 77", done, busy, data_out);
    end
    tick();
    total++;
    if (done !== 0 || busy !== 0) begin
      bad++; $display("FAIL zero_rows_after: got done=%b busy=%b want 0 0", done, busy);
    end
    start = 1; rows = 3; cols = 0; tick(); start = 0;
    total++;
    if (done !== 1 || busy !== 0 || data_out !== 16'd77) begin
      bad++;
      $display("FAIL zero_cols: got done=%b busy=%b addr=%0d, want 1 0 77", done, busy, data_out);
    end
    tick();
  endtask

  task automatic test_wrap();
    set_k(16'd1);
    run_walk("wrap", 16'hFFFE, 16'd1, 1'b0, 1, 4, 0, -1);
    tick();
  endtask

  task automatic test_reset_mid_walk();
    set_k(16'd4);
    start = 1; data_in = 16'd200; mode = 0; rows = 3; cols = 3; tick(); start = 0;
    inc = 1; inck = 1; load_enable = 1; data_in = 16'd9; tick(); tick();
    inc = 0; inck = 0; load_enable = 0;
    total++;
    if (data_out !== 16'd200 || busy !== 1) begin
      bad++; $display("FAIL manual_in_walk: got addr=%0d busy=%b want 200 1", data_out, busy);
    end
    step = 1; tick();
    total++;
    if (data_out !== 16'd201) begin bad++; $display("FAIL walk_step: got %0d want 201", data_out); end
    reset = 1; tick(); reset = 0; step = 0;
    total++;
    if (busy !== 0 || data_out !== 16'd0 || done !== 0 || last !== 0 || k_out !== 16'd332) begin
      bad++;
      $display("FAIL reset_in_walk: got busy=%b addr=%0d done=%b last=%b k=%0d, want 0 0 0 0 332",
               busy, data_out, done, last, k_out);
    end
    tick();
    total++;
    if (done !== 0 || busy !== 0) begin
      bad++; $display("FAIL reset_in_walk_after: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    set_k(16'd7);
    run_walk("b2b_first", 16'd1000, 16'd7, 1'b0, 2, 2, 0, -1);
    run_walk("b2b_second", 16'd2000, 16'd7, 1'b1, 3, 2, 0, -1);
    tick();
  endtask

  task automatic test_random_walks();
    logic [15:0] kk, base;
    for (int n = 0; n < 8; n++) begin
      kk = 16'($urandom);
      base = 16'($urandom);
      set_k(kk);
      run_walk($sformatf("rand%0d", n), base, kk, 1'($urandom_range(1)),
               $urandom_range(1, 4), $urandom_range(1, 5), 30, -1);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_priority();
    test_row_walk();
    test_col_walk_stall();
    test_zero_dims();
    test_wrap();
    test_reset_mid_walk();
    test_back_to_back();
    test_random_walks();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
